// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler: arbitrates NUM_REQ byte requesters onto one 8N1 tx line.
// Define UART_TX_SCHED_TWO_STOP_EN to append a second stop bit (8N2 frames).
module uart_tx_sched #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 baud_en,
    input  logic                 baud_tick,
    output logic                 tx,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_idx
);

    localparam int unsigned NumSlots = 2 ** IDX_W;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef UART_TX_SCHED_TWO_STOP_EN
        , StStop2
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             tx_q, tx_d;

    // Pad requesters up to a power of two so the grant index selects without width games.
    logic [NumSlots-1:0] valid_pad;
    logic [7:0]          data_arr [NumSlots];
    logic                found;
    logic [IDX_W-1:0]    sel;
    int unsigned         cand;

    always_comb begin
        valid_pad = '0;
        for (int i = 0; i < NumSlots; i++) begin
            data_arr[i] = 8'h00;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            valid_pad[i] = req_valid[i];
            data_arr[i]  = req_data[8*i +: 8];
        end
        found = 1'b0;
        sel   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && valid_pad[IDX_W'(cand)]) begin
                found = 1'b1;
                sel   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                if (found && !rst) begin
                    req_ready = NUM_REQ'(1) << sel;
                    state_d   = StStart;
                    shift_d   = data_arr[sel];
                    grant_d   = sel;
                    rr_d      = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    state_d = StData;
                    cnt_d   = 3'd0;
                end
            end
            StData: begin
                if (baud_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (baud_tick) begin
`ifdef UART_TX_SCHED_TWO_STOP_EN
                    state_d = StStop2;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef UART_TX_SCHED_TWO_STOP_EN
            StStop2: begin
                if (baud_tick) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // tx is registered from the next state so it lines up with the state register.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
            grant_q <= '0;
            rr_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            tx_q    <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != StIdle);
    assign baud_en   = (state_q != StIdle);
    assign grant_idx = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised bench for uart_tx_sched: frame-level reference model plus directed literal checks.
module tb_uart_tx_sched;
    localparam int N = 4;
`ifdef UART_TX_SCHED_TWO_STOP_EN
    localparam int NSTOP      = 2;
    localparam int BUSY_104   = 1144;
    localparam int RR_GAP_P4  = 45;
`else
    localparam int NSTOP      = 1;
    localparam int BUSY_104   = 1040;
    localparam int RR_GAP_P4  = 41;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           baud_en;
    logic           baud_tick;
    logic           tx;
    logic           busy;
    logic [1:0]     grant_idx;

    uart_tx_sched #(.NUM_REQ(N), .IDX_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .baud_en   (baud_en),
        .baud_tick (baud_tick),
        .tx        (tx),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int P = 4;
    int tcnt = 0;
    int cyc = 0;
    int busy_cnt = 0;
    bit noise = 1'b0;
    bit noise_on = 1'b0;

    // Stand-in for baud_tick_gen: reloads while disabled, ticks every P enabled cycles.
    // Spurious ticks while disabled must be ignored by the scheduler.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        tcnt  <= baud_en ? ((tcnt == P - 1) ? 0 : tcnt + 1) : 0;
        noise <= noise_on && ($urandom_range(0, 2) == 0);
    end
    assign baud_tick = baud_en ? (tcnt == P - 1) : noise;

    // Reference model: a frame is the bit string {0, d0..d7, 1[,1]}, each bit held P cycles.
    bit          m_busy = 1'b0;
    int          m_k = 0;
    logic [7:0]  m_byte = 8'h00;
    int          m_grant = 0;
    int          m_rr = 0;
    logic [N-1:0] rdy_last = '0;

    function automatic logic frame_bit(logic [7:0] b, int j);
        logic [7:0] t;
        if (j == 0) return 1'b0;
        if (j <= 8) begin
            t = b >> (j - 1);
            return t[0];
        end
        return 1'b1;
    endfunction

    logic [N-1:0] e_rdy;
    logic         e_tx;
    int           m_sel;
    int           m_i;

    always @(negedge clk) begin
        rdy_last = req_ready;
        busy_cnt = busy_cnt + (busy ? 1 : 0);
        if (rst) begin
            m_busy  = 1'b0;
            m_k     = 0;
            m_grant = 0;
            m_rr    = 0;
        end else begin
            m_sel = -1;
            e_rdy = '0;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    m_i = (m_rr + k) % N;
                    if (m_sel < 0 && req_valid[m_i]) m_sel = m_i;
                end
            end
            if (m_sel >= 0) e_rdy[m_sel] = 1'b1;
            e_tx = m_busy ? frame_bit(m_byte, m_k / P) : 1'b1;
            n_cmp++;
            if (req_ready !== e_rdy || tx !== e_tx || busy !== m_busy ||
                baud_en !== m_busy || grant_idx !== 2'(m_grant)) begin
                n_bad++;
                $display("FAIL model t=%0t: ready %b/%b tx %b/%b busy %b/%b en %b grant %0d/%0d",
                         $time, req_ready, e_rdy, tx, e_tx, busy, m_busy, baud_en,
                         grant_idx, m_grant);
            end
            if (m_sel >= 0) begin
                m_busy  = 1'b1;
                m_k     = 0;
                m_byte  = req_data[8*m_sel +: 8];
                m_grant = m_sel;
                m_rr    = (m_sel + 1) % N;
            end else if (m_busy) begin
                m_k++;
                if (m_k == (9 + NSTOP) * P) m_busy = 1'b0;
            end
        end
    end

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int idx, output int at_cyc);
        idx = -1;
        at_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (|req_ready) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                at_cyc = cyc;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_ready: got no req_ready expected a grant within 3000 cycles");
    endtask

    task automatic reset_dut(int new_p);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        P = new_p;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    int g, c0, c1, lows;
    int exp55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_baud_en", int'(baud_en), 0);
        check("reset_ready", int'(req_ready), 0);
        check("reset_grant", int'(grant_idx), 0);

        // Single byte 0x55 on requester 0, 104-cycle bit period.
        @(posedge clk);
        #1;
        rst = 1'b0;
        P = 104;
        busy_cnt = 0;
        req_data[7:0] = 8'h55;
        req_valid = 4'b0001;
        wait_ready(g, c0);
        check("single_grant", g, 0);
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int j = 0; j < 10; j++) begin
            repeat (j == 0 ? P / 2 + 1 : P) @(negedge clk);
            check("single_tx_bit", int'(tx), exp55[j]);
        end
        repeat (3 * P) @(negedge clk);
        check("single_busy_cycles", busy_cnt, BUSY_104);
        check("single_idle", int'(busy), 0);

        // Round-robin between two continuously valid requesters.
        reset_dut(4);
        req_data = {8'h00, 8'h00, 8'h22, 8'h11};
        req_valid = 4'b0011;
        for (int n = 0; n < 4; n++) begin
            wait_ready(g, c1);
            check("rr_grant", g, n % 2);
            if (n > 0) check("rr_gap", c1 - c0, RR_GAP_P4);
            c0 = c1;
        end
        @(posedge clk);
        #1;
        req_valid = '0;

        // Fairness after a skipped pointer position.
        reset_dut(4);
        req_data[23:16] = 8'h33;
        req_valid = 4'b0100;
        wait_ready(g, c0);
        check("fair_grant0", g, 2);
        @(posedge clk);
        #1;
        req_data[15:8] = 8'h44;
        req_data[31:24] = 8'h66;
        req_valid = 4'b1010;
        wait_ready(g, c0);
        check("fair_grant1", g, 3);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        wait_ready(g, c0);
        check("fair_grant2", g, 1);
        @(posedge clk);
        #1;
        req_valid = '0;

        // Reset in the middle of a 0xA5 data phase.
        reset_dut(4);
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        wait_ready(g, c0);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3 * P) @(posedge clk);
        @(negedge clk);
        check("midframe_busy", int'(busy), 1);
        check("midframe_grant", int'(grant_idx), 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_baud_en", int'(baud_en), 0);
        check("abort_ready", int'(req_ready), 0);
        check("abort_grant", int'(grant_idx), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lows = 0;
        repeat (3 * P) begin
            @(negedge clk);
            lows += (tx ? 0 : 1) + (busy ? 1 : 0);
        end
        check("abort_no_resume", lows, 0);

        // Randomised traffic with spurious idle ticks.
        noise_on = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            reset_dut($urandom_range(2, 7));
            for (int c = 0; c < 1500; c++) begin
                @(posedge clk);
                #1;
                for (int i = 0; i < N; i++) begin
                    if (rdy_last[i]) begin
                        req_valid[i] = ($urandom_range(0, 1) == 1);
                        req_data[8*i +: 8] = 8'($urandom);
                    end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
